// File: rtl/cv32e40p_apu_responder.sv
// Local APU responder for the core's shared-APU request interface.
// Runs ADD/SUB/MUL/MAC on a fixed-latency pipeline and DIVU/REMU on an
// iterative restoring divider (one quotient bit per cycle). Results return
// in grant order through a single registered output stage.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   apu_req_i/apu_gnt_o request handshake (gnt is combinational)
//   apu_operands_i      operands a=[0], b=[1], c=[2]
//   apu_op_i            opcode (0 ADD,1 SUB,2 MUL,3 MAC,4 DIVU,5 REMU)
//   apu_flags_i         bit0 = saturate for ADD/SUB
//   apu_rvalid_o        one-cycle result strobe
//   apu_result_o        result, zero when apu_rvalid_o is low
//   apu_flags_o         {invalid, div0, saturated, overflow, zero}
//   busy_o              any operation in flight
module cv32e40p_apu_responder #(
   parameter int unsigned LATENCY          = 2,
   parameter int unsigned APU_NARGS_CPU    = 3,
   parameter int unsigned APU_WOP_CPU      = 6,
   parameter int unsigned APU_NDSFLAGS_CPU = 15,
   parameter int unsigned APU_NUSFLAGS_CPU = 5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        apu_req_i,
   output logic                        apu_gnt_o,
   input  logic [31:0]                 apu_operands_i [APU_NARGS_CPU],
   input  logic [APU_WOP_CPU-1:0]      apu_op_i,
   input  logic [APU_NDSFLAGS_CPU-1:0] apu_flags_i,
   output logic                        apu_rvalid_o,
   output logic [31:0]                 apu_result_o,
   output logic [APU_NUSFLAGS_CPU-1:0] apu_flags_o,
   output logic                        busy_o
);

   localparam int unsigned DW   = 32;
   localparam int unsigned FW   = 5;
   localparam int unsigned LAST = LATENCY - 1;

   localparam logic [APU_WOP_CPU-1:0] OP_ADD  = APU_WOP_CPU'(0);
   localparam logic [APU_WOP_CPU-1:0] OP_SUB  = APU_WOP_CPU'(1);
   localparam logic [APU_WOP_CPU-1:0] OP_MUL  = APU_WOP_CPU'(2);
   localparam logic [APU_WOP_CPU-1:0] OP_MAC  = APU_WOP_CPU'(3);
   localparam logic [APU_WOP_CPU-1:0] OP_DIVU = APU_WOP_CPU'(4);
   localparam logic [APU_WOP_CPU-1:0] OP_REMU = APU_WOP_CPU'(5);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;

   state_e          state;
   logic [4:0]      count_q;
   logic [DW-1:0]   quo_q;
   logic [DW-1:0]   dsor_q;
   logic [DW:0]     rem_q;
   logic            op_rem_q;
   logic            dz_q;

   logic [LATENCY-1:0] stg_vld;
   logic [DW-1:0]      stg_res [LATENCY];
   logic [FW-1:0]      stg_flg [LATENCY];
   logic               out_pipe_q;

   logic [LATENCY-1:0] sin_v;
   logic [DW-1:0]      sin_res [LATENCY];
   logic [FW-1:0]      sin_flg [LATENCY];
   logic               pipe_into_last;

   logic [DW-1:0] op_a, op_b, op_c, sum, dif, prod;
   logic [DW-1:0] calc_res;
   logic [FW-1:0] calc_flg;
   logic          ovf;
   logic          is_div_op, drain, pipe_go, div_go;
   logic [DW:0]   rem_sh;
   logic          div_ge;
   logic [DW-1:0] div_res;
   logic [FW-1:0] div_flg;
   logic          unused_bits;

   assign op_a = apu_operands_i[0];
   assign op_b = apu_operands_i[1];
   assign op_c = apu_operands_i[2];
   assign unused_bits = ^{apu_flags_i[APU_NDSFLAGS_CPU-1:1], rem_q[DW]};

   // Pipelined-path result and flags, evaluated in the grant cycle
   always_comb begin
      sum      = op_a + op_b;
      dif      = op_a - op_b;
      prod     = op_a * op_b;
      calc_res = '0;
      calc_flg = '0;
      ovf      = 1'b0;
      case (apu_op_i)
         OP_ADD: begin
            calc_res = sum;
            ovf      = (op_a[DW-1] == op_b[DW-1]) && (sum[DW-1] != op_a[DW-1]);
         end
         OP_SUB: begin
            calc_res = dif;
            ovf      = (op_a[DW-1] != op_b[DW-1]) && (dif[DW-1] != op_a[DW-1]);
         end
         OP_MUL:  calc_res = prod;
         OP_MAC:  calc_res = prod + op_c;
         OP_DIVU, OP_REMU: calc_res = '0;
         default: calc_flg[4] = 1'b1;
      endcase
      calc_flg[1] = ovf;
      // Overflow direction follows the sign of a in both ADD and SUB
      if (ovf && apu_flags_i[0]) begin
         calc_flg[2] = 1'b1;
         calc_res    = op_a[DW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      calc_flg[0] = (calc_res == '0);
   end

   // Pipeline holds a result of its own (a divider result in the last stage does not count)
   always_comb begin
      drain = out_pipe_q;
      for (int unsigned i = 0; i < LAST; i++) drain = drain | stg_vld[i];
   end

   // Grant: divider must be idle and the pipeline empty before a divide is accepted
   always_comb begin
      is_div_op = (apu_op_i == OP_DIVU) || (apu_op_i == OP_REMU);
      apu_gnt_o = apu_req_i;
      if (state == S_DIV) apu_gnt_o = 1'b0;
      else if (is_div_op && (drain || state == S_DONE)) apu_gnt_o = 1'b0;
      // With a single stage a DONE-cycle grant would land on the divider's output edge
      else if (state == S_DONE && LATENCY == 1) apu_gnt_o = 1'b0;
      pipe_go = apu_gnt_o && !is_div_op;
      div_go  = apu_gnt_o && is_div_op;
   end

   // Divider datapath helpers
   always_comb begin
      rem_sh  = {rem_q[DW-1:0], quo_q[DW-1]};
      div_ge  = (rem_sh >= {1'b0, dsor_q});
      div_res = op_rem_q ? rem_q[DW-1:0] : quo_q;
      div_flg = {1'b0, dz_q, 2'b00, (div_res == '0)};
   end

   // Divider FSM: IDLE -> DIV (32 iterations) -> DONE, or IDLE -> DONE on b == 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         count_q  <= '0;
         quo_q    <= '0;
         dsor_q   <= '0;
         rem_q    <= '0;
         op_rem_q <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (div_go) begin
                  op_rem_q <= (apu_op_i == OP_REMU);
                  dsor_q   <= op_b;
                  count_q  <= 5'd31;
                  if (op_b == '0) begin
                     // Preload the divide-by-zero answers so DONE needs no special case
                     dz_q  <= 1'b1;
                     quo_q <= '1;
                     rem_q <= {1'b0, op_a};
                     state <= S_DONE;
                  end else begin
                     dz_q  <= 1'b0;
                     quo_q <= op_a;
                     rem_q <= '0;
                     state <= S_DIV;
                  end
               end
            end
            S_DIV: begin
               quo_q   <= {quo_q[DW-2:0], div_ge};
               rem_q   <= div_ge ? (rem_sh - {1'b0, dsor_q}) : rem_sh;
               count_q <= count_q - 5'd1;
               if (count_q == 5'd0) state <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Stage inputs; the last stage doubles as the output register shared with the divider
   always_comb begin
      sin_v = '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
         sin_res[i] = '0;
         sin_flg[i] = '0;
      end
      sin_v[0]   = pipe_go;
      sin_res[0] = calc_res;
      sin_flg[0] = calc_flg;
      for (int unsigned i = 1; i < LATENCY; i++) begin
         sin_v[i]   = stg_vld[i-1];
         sin_res[i] = stg_res[i-1];
         sin_flg[i] = stg_flg[i-1];
      end
      pipe_into_last = sin_v[LAST];
      if (state == S_DONE) begin
         sin_v[LAST]   = 1'b1;
         sin_res[LAST] = div_res;
         sin_flg[LAST] = div_flg;
      end
   end

   // Stage registers; data is zeroed when its valid is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_vld    <= '0;
         out_pipe_q <= 1'b0;
         for (int unsigned i = 0; i < LATENCY; i++) begin
            stg_res[i] <= '0;
            stg_flg[i] <= '0;
         end
      end else begin
         stg_vld    <= sin_v;
         out_pipe_q <= pipe_into_last;
         for (int unsigned i = 0; i < LATENCY; i++) begin
            stg_res[i] <= sin_v[i] ? sin_res[i] : '0;
            stg_flg[i] <= sin_v[i] ? sin_flg[i] : '0;
         end
      end
   end

   assign apu_rvalid_o = stg_vld[LAST];
   assign apu_result_o = stg_res[LAST];
   assign apu_flags_o  = APU_NUSFLAGS_CPU'(stg_flg[LAST]);
   assign busy_o       = drain || (state != S_IDLE);

   // Pipeline and divider must never complete into the output stage together
   a_one_source: assert property (@(posedge clk) disable iff (!rst_n)
      !(pipe_into_last && state == S_DONE));

endmodule

// File: tb/tb_cv32e40p_apu_responder.sv
// Self-checking bench for cv32e40p_apu_responder: directed cases plus random
// requests, checked every cycle against an interval-based reference model.
module tb_cv32e40p_apu_responder;

   localparam int unsigned LATENCY = 2;
   localparam int unsigned NARGS   = 3;
   localparam int unsigned WOP     = 6;
   localparam int unsigned NDS     = 15;
   localparam int unsigned NUS     = 5;
   localparam longint      MAXP    = 64'sd2147483647;
   localparam longint      MINN    = -64'sd2147483648;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             apu_req;
   logic             apu_gnt;
   logic [31:0]      ops [NARGS];
   logic [WOP-1:0]   op;
   logic [NDS-1:0]   flg_i;
   logic             apu_rvalid;
   logic [31:0]      apu_result;
   logic [NUS-1:0]   apu_flags;
   logic             busy;

   cv32e40p_apu_responder #(
      .LATENCY(LATENCY), .APU_NARGS_CPU(NARGS), .APU_WOP_CPU(WOP),
      .APU_NDSFLAGS_CPU(NDS), .APU_NUSFLAGS_CPU(NUS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .apu_req_i(apu_req), .apu_gnt_o(apu_gnt),
      .apu_operands_i(ops), .apu_op_i(op), .apu_flags_i(flg_i),
      .apu_rvalid_o(apu_rvalid), .apu_result_o(apu_result),
      .apu_flags_o(apu_flags), .busy_o(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      int          due;
      logic [31:0] res;
      logic [4:0]  flg;
   } exp_t;

   exp_t exp_q[$];
   int   pg[$];          // grant cycles of pipelined ops
   int   dv_g    = -1;   // grant cycle of latest divide
   int   dv_done = -1;   // its DONE cycle

   // Reference arithmetic straight from the opcode definitions
   function automatic void ref_op(input logic [5:0] o, input logic [31:0] a, b, c,
                                  input logic sat, output logic [31:0] r, output logic [4:0] f);
      longint s;
      logic   v;
      r = '0;
      f = '0;
      case (o)
         6'd0, 6'd1: begin
            s = (o == 6'd0) ? longint'($signed(a)) + longint'($signed(b))
                            : longint'($signed(a)) - longint'($signed(b));
            r = 32'(s);
            v = (s > MAXP) || (s < MINN);
            f[1] = v;
            if (sat && v) begin
               r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
               f[2] = 1'b1;
            end
         end
         6'd2: r = a * b;
         6'd3: r = a * b + c;
         6'd4: begin
            if (b == 0) begin r = 32'hFFFF_FFFF; f[3] = 1'b1; end
            else r = a / b;
         end
         6'd5: begin
            if (b == 0) begin r = a; f[3] = 1'b1; end
            else r = a % b;
         end
         default: f[4] = 1'b1;
      endcase
      f[0] = (r == 0);
   endfunction

   int   mt;
   logic m_po, m_isd, m_eg, m_eb, m_erv;
   exp_t m_e;

   // Per-cycle monitor: grant, busy and response checked against the model
   always @(negedge clk) begin
      if (rst_n) begin
         mt = cyc;
         while (pg.size() > 0 && pg[0] + int'(LATENCY) < mt) void'(pg.pop_front());
         m_po = 1'b0;
         foreach (pg[i]) if (mt >= pg[i] + 1 && mt <= pg[i] + int'(LATENCY)) m_po = 1'b1;
         m_isd = (op == 6'd4) || (op == 6'd5);

         if (!apu_req) m_eg = 1'b0;
         else if (dv_done >= 0 && mt > dv_g && mt < dv_done) m_eg = 1'b0;
         else if (dv_done == mt) m_eg = !m_isd && (LATENCY != 1);
         else if (m_isd && m_po) m_eg = 1'b0;
         else m_eg = 1'b1;
         check("gnt", 64'(apu_gnt), 64'(m_eg));

         m_eb = m_po || (dv_done >= 0 && mt > dv_g && mt <= dv_done);
         check("busy", 64'(busy), 64'(m_eb));

         m_erv = (exp_q.size() > 0) && (exp_q[0].due == mt);
         check("rvalid", 64'(apu_rvalid), 64'(m_erv));
         if (m_erv) begin
            m_e = exp_q.pop_front();
            check("result", 64'(apu_result), 64'(m_e.res));
            check("flags", 64'(apu_flags), 64'(m_e.flg));
         end else begin
            check("idle_out", 64'({apu_result, apu_flags}), 64'(0));
         end

         if (apu_gnt && apu_req) begin
            ref_op(op, ops[0], ops[1], ops[2], flg_i[0], m_e.res, m_e.flg);
            if (m_isd) begin
               m_e.due = mt + ((ops[1] == 0) ? 2 : 34);
               dv_g    = mt;
               dv_done = (ops[1] == 0) ? mt + 1 : mt + 33;
            end else begin
               m_e.due = mt + int'(LATENCY);
               pg.push_back(mt);
            end
            exp_q.push_back(m_e);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Hold a request until granted; returns just after the transfer edge
   task automatic send(input logic [5:0] o, input logic [31:0] a, b, c, input logic sat);
      int n;
      n = 0;
      apu_req = 1'b1;
      op      = o;
      ops[0]  = a;
      ops[1]  = b;
      ops[2]  = c;
      flg_i   = {14'($urandom), sat};
      do begin @(negedge clk); n++; end while (!apu_gnt && n < 200);
      if (!apu_gnt) check("gnt_timeout", 64'(apu_gnt), 64'(1));
      @(posedge clk); #1;
      apu_req = 1'b0;
   endtask

   int unsigned r;
   logic [5:0]  ro;
   logic [31:0] ra, rb, rc;
   logic        rs;
   int          w;

   initial begin
      apu_req = 1'b0;
      op      = '0;
      ops     = '{default: 32'd0};
      flg_i   = '0;
      rst_n   = 1'b0;
      idle(3);
      check("reset_rvalid", 64'(apu_rvalid), 64'(0));
      check("reset_result", 64'(apu_result), 64'(0));
      check("reset_flags", 64'(apu_flags), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      rst_n = 1'b1;
      idle(1);

      send(6'd0, 32'd5, 32'd7, 32'd0, 1'b0);
      idle(3);
      send(6'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b1);
      send(6'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0);
      idle(3);
      send(6'd2, 32'd3, 32'd4, 32'd0, 1'b0);
      send(6'd3, 32'd2, 32'd3, 32'd4, 1'b0);
      send(6'd1, 32'd9, 32'd9, 32'd0, 1'b0);
      idle(3);
      // divide right behind a MUL, then a MUL queued behind the divide
      send(6'd2, 32'd5, 32'd6, 32'd0, 1'b0);
      send(6'd4, 32'd100, 32'd7, 32'd0, 1'b0);
      send(6'd2, 32'd6, 32'd7, 32'd0, 1'b0);
      idle(4);
      send(6'd5, 32'd100, 32'd7, 32'd0, 1'b0);
      idle(38);
      send(6'd4, 32'd55, 32'd0, 32'd0, 1'b0);
      idle(3);
      send(6'd5, 32'd55, 32'd0, 32'd0, 1'b0);
      idle(3);
      send(6'd9, 32'd1, 32'd2, 32'd3, 1'b0);
      idle(4);

      // reset in the middle of a divide
      send(6'd4, 32'd100, 32'd7, 32'd0, 1'b0);
      idle(9);
      rst_n = 1'b0;
      exp_q.delete();
      pg.delete();
      dv_g    = -1;
      dv_done = -1;
      #1;
      check("midrst_rvalid", 64'(apu_rvalid), 64'(0));
      check("midrst_result", 64'(apu_result), 64'(0));
      check("midrst_flags", 64'(apu_flags), 64'(0));
      check("midrst_busy", 64'(busy), 64'(0));
      idle(3);
      rst_n = 1'b1;
      idle(40);
      send(6'd0, 32'd1, 32'd1, 32'd0, 1'b0);
      idle(4);

      for (int k = 0; k < 150; k++) begin
         r  = $urandom_range(0, 9);
         ra = $urandom;
         rb = $urandom;
         rc = $urandom;
         rs = 1'b0;
         if ($urandom_range(0, 1) == 1) begin
            ra = $urandom_range(0, 2000);
            rb = $urandom_range(0, 50);
         end
         case (r)
            0, 1, 2, 3, 4, 5: ro = 6'(r);
            6: begin ro = 6'd0; rs = 1'b1; end
            7: begin ro = 6'd1; rs = 1'b1; end
            8: ro = 6'($urandom_range(6, 63));
            default: begin ro = 6'($urandom_range(4, 5)); rb = 32'd0; end
         endcase
         send(ro, ra, rb, rc, rs);
         idle($urandom_range(0, 2));
      end

      w = 0;
      while (exp_q.size() > 0 && w < 100) begin idle(1); w++; end
      check("drain", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cv32e40p_apu_responder.md
Name: cv32e40p_apu_responder

Overview:
- APU-side responder for the core's shared-APU request interface: accepts core requests on a req/gnt handshake, executes them, and returns apu_rvalid with result and flags.
- Provides a fixed-latency pipelined path for ADD, SUB, MUL and MAC, and an iterative 1-bit-per-cycle path for DIVU and REMU.
- Used as the default local APU in core-only and FPU-less configurations.
- Results return strictly in grant order. The core has no backpressure on the response channel.

Parameters:
- LATENCY, 2, number of register stages in the pipelined path (legal range 1..4).
- APU_NARGS_CPU, 3, number of operands.
- APU_WOP_CPU, 6, opcode width.
- APU_NDSFLAGS_CPU, 15, width of the downstream (request) flags.
- APU_NUSFLAGS_CPU, 5, width of the upstream (response) flags.

Ports:
- clk  input  1  core clock; all state is on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- apu_req_i  input  1  request valid; held until granted.
- apu_gnt_o  output  1  grant, combinational from req and internal state.
- apu_operands_i  input  APU_NARGS_CPU x 32  operands a=[0], b=[1], c=[2].
- apu_op_i  input  APU_WOP_CPU  opcode.
- apu_flags_i  input  APU_NDSFLAGS_CPU  bit0 = saturate, applies to ADD/SUB only; other bits ignored.
- apu_rvalid_o  output  1  one-cycle result strobe.
- apu_result_o  output  32  result, valid while apu_rvalid_o=1.
- apu_flags_o  output  APU_NUSFLAGS_CPU  status flags, valid while apu_rvalid_o=1.
- busy_o  output  1  high while any operation is in flight.

Behaviour:
- Opcodes: 0 ADD (a+b), 1 SUB (a-b), 2 MUL (low 32 bits of a*b), 3 MAC (low 32 bits of a*b+c), 4 DIVU (a/b), 5 REMU (a%b). Any other opcode is invalid.
- apu_flags_o bits:
  - [0] zero: result == 0.
  - [1] signed overflow: ADD/SUB only.
  - [2] saturated.
  - [3] divide by zero.
  - [4] invalid opcode.
- Saturation: ADD/SUB with flags_i[0]=1 and signed overflow give 0x7FFFFFFF (positive overflow) or 0x80000000 (negative overflow), and set bits [1] and [2].
- Invalid opcode: takes the pipelined path; result 0, flags 5'b10001.
- Handshake: a transfer occurs when apu_req_i && apu_gnt_o. The request fields are sampled in that cycle.
- Grant rules:
  - apu_gnt_o=0 while state is DIV.
  - apu_gnt_o=0 when the request is DIVU/REMU and the pipeline holds any valid stage (drain first).
  - Otherwise apu_gnt_o = apu_req_i.
- Pipelined path:
  - The result is computed at grant and shifted through LATENCY valid/data stages.
  - apu_rvalid_o rises exactly LATENCY cycles after the grant cycle.
  - Throughput is 1 per cycle; back-to-back grants give back-to-back rvalid.
- Divider FSM, states IDLE -> DIV -> DONE -> IDLE:
  - IDLE: a granted DIVU/REMU loads dividend, divisor, a 33-bit remainder register cleared to 0, and count=31, then goes to DIV.
  - DIV: performs one restoring iteration per cycle for 32 cycles, decrementing count; at count 0 goes to DONE.
  - DONE: drives apu_rvalid_o=1 with the quotient or remainder, then returns to IDLE.
  - Latency is 34 cycles from grant to rvalid.
  - A new grant is possible in the DONE cycle, but only for a pipelined op.
- Divide by zero (b=0): skips DIV and goes IDLE -> DONE next cycle (latency 2). DIVU returns 0xFFFFFFFF, REMU returns a; flags [3]=1.
- Output mux: at most one of {pipeline last stage, divider DONE} can be valid in a cycle, guaranteed by the grant rules. A simultaneous-valid condition is an assertion failure.
- busy_o = any pipeline stage valid || state != IDLE.
- Reset (rst_n low, asynchronous, at any time including mid-divide or mid-pipeline):
  - all valid bits cleared, state=IDLE, count=0;
  - apu_rvalid_o=0, apu_result_o=0, apu_flags_o=0, busy_o=0;
  - in-flight operations are discarded; no rvalid follows.
  - Data registers are cleared to 0 as well, so outputs are deterministic.
- Outputs: apu_result_o and apu_flags_o are 0 whenever apu_rvalid_o=0.
- Arithmetic: all operations are 32-bit wrap-around.
  - Overflow: ADD when sign(a)==sign(b) and sign(sum)!=sign(a); SUB when sign(a)!=sign(b) and sign(diff)!=sign(a).

Test Plan:
- Reset, then ADD a=5, b=7 with LATENCY=2: gnt in cycle 0, rvalid in cycle 2, result 12, flags 0.
- Saturation: ADD a=0x7FFFFFFF, b=1, flags_i[0]=1 -> result 0x7FFFFFFF, flags 5'b00110. Same operation with flags_i[0]=0 -> result 0x80000000, flags 5'b00010.
- Back-to-back MUL 3*4, MAC 2*3+4, SUB 9-9: three consecutive grants -> three consecutive rvalids with results 12, 10, 0; flags 0, 0, 5'b00001.
- DIVU 100/7 requested one cycle after a MUL: gnt held low until the pipeline drains, then granted; rvalid 34 cycles after grant with result 14. Next REMU 100/7 -> result 2. A MUL requested during DIV is not granted until the DONE cycle.
- Divide by zero and invalid opcode: DIVU 55/0 -> rvalid 2 cycles after grant, result 0xFFFFFFFF, flags 5'b01000. REMU 55/0 -> result 55, flags 5'b01000. op=9 -> result 0, flags 5'b10001.
- Reset mid-divide: assert rst_n=0 at DIV cycle 10 -> outputs 0 immediately, no later rvalid. After release, ADD 1+1 -> result 2 at LATENCY.
